uop_queue: RTL and testbench
============================

// Module: uop_queue
// PURPOSE
// - Micro-op issue buffer directly downstream of the front end; consumes decoded bundles (1..3 uops + 16-bit constant k).
// - Stores each uop with its bundle's k in a ring FIFO; issues one uop per cycle to execute via valid/ready.
// - Drives the front end's feed request, exposes occupancy, and discards all contents on an execute-side flush.
// PARAMETERS
// - DEPTH  8   entries; power of two, >= 4
// - UOP_W  20  micro-op width
// - K_W    16  constant/forwarded-PC width
// PORTS
// - clk           in   1       clock, all state on rising edge
// - a_rst         in   1       asynchronous, active-low reset
// - fe_feed_req   out  1       queue can accept a full 3-uop bundle this cycle
// - fe_feed_ack   in   1       front end presents a bundle this cycle
// - fe_uop_0..2   in   UOP_W   bundle uops; uop_0 is the oldest
// - fe_uop_count  in   2       number of valid uops in the bundle (0..3)
// - fe_k          in   K_W     bundle constant, stored with every uop of the bundle
// - ex_flush      in   1       discard contents (PC redirect)
// - ex_valid      out  1       ex_uop/ex_k valid
// - ex_ready      in   1       execute consumes the head entry
// - ex_uop        out  UOP_W   head uop; 0 when !ex_valid
// - ex_k          out  K_W     head constant; 0 when !ex_valid
// - occupancy     out  $clog2(DEPTH)+1  entries currently stored
// BEHAVIOUR
// - Reset (a_rst low): rd_ptr = wr_ptr = occupancy = 0; ex_valid = 0, ex_uop = 0, ex_k = 0. Storage RAM is not reset.
// - fe_feed_req = (DEPTH - occupancy >= 3) & ~ex_flush; combinational, never depends on fe_feed_ack.
// - push = fe_feed_req & fe_feed_ack; writes fe_uop_0..N-1 (N = fe_uop_count) at wr_ptr, wr_ptr+1, wr_ptr+2 mod DEPTH; wr_ptr += N.
// - N = 0 with push: handshake completes, nothing stored, pointers unchanged.
// - fe_feed_ack while fe_feed_req = 0: bundle ignored, no state change; the front end holds it.
// - pop = ex_valid & ex_ready; rd_ptr += 1 mod DEPTH.
// - Same-cycle push and pop: occupancy_next = occupancy + N - pop; occupancy never exceeds DEPTH, never underflows.
// - ex_valid = (occupancy != 0); head registered in storage, so a pushed uop is first visible the cycle after the push.
// - Issue order is strict FIFO across bundles and across pointer wrap-around; ex_k always matches the uop's own bundle.
// - ex_flush: next cycle rd_ptr = wr_ptr = occupancy = 0; the bundle and pop of the flush cycle are both discarded; ex_valid = 0 for at least that next cycle.
// - Flush has priority over push and pop; reset has priority over everything.
// - Reset asserted mid-operation: queue empties asynchronously; partially written bundles are lost.
// CONFIGURATION
// - UOP_QUEUE_BYPASS_EN defined: when occupancy = 0 and a push with N >= 1 occurs, fe_uop_0/fe_k drive ex_uop/ex_k combinationally with ex_valid = 1 in the push cycle.
//   If ex_ready is also 1, uop_0 is not written; only uops 1..N-1 are stored. If ex_ready is 0, uop_0 is stored normally. Bypass is suppressed during ex_flush.
// - UOP_QUEUE_BYPASS_EN undefined: no bypass; minimum push-to-issue latency is 1 cycle.
// STRUCTURE
// - Shared package uop_pkg: UOP_W, K_W, default DEPTH, typedef uop_entry_t {uop, k}, MAX_BUNDLE = 3.
// - Sub-module uop_ring: DEPTH x uop_entry_t storage, 3 write ports (consecutive addresses, per-port enable), 1 async read port.
// - Top level holds pointers, occupancy, handshake, flush and bypass logic.
// TESTING
// - Reset: release a_rst -> fe_feed_req = 1, ex_valid = 0, ex_uop = 0, occupancy = 0.
// - Bundle order: push N=3 uops 0x00001/0x00002/0x00003, k = 0x1234, ex_ready = 1 -> issued on the next 3 cycles in order, ex_k = 0x1234 each cycle.
// - Full: DEPTH = 8, ex_ready = 0, push two N=3 bundles -> occupancy 6, fe_feed_req = 0, further fe_feed_ack ignored; one pop -> occupancy 5, fe_feed_req = 1.
// - Wrap: wr_ptr = 6, push N=3 (0xA, 0xB, 0xC) -> stored at 6, 7, 0; issued 0xA, 0xB, 0xC; N=0 push leaves occupancy unchanged.
// - Flush: occupancy 4, same-cycle push N=2 and pop, ex_flush = 1 -> next cycle occupancy 0, ex_valid = 0; dropped uops never issue.
// - Bypass: empty, push N=2 with ex_ready = 1 -> with macro, uop_0 issues in the push cycle and uop_1 the next cycle; without macro, uop_0 issues at +1 and uop_1 at +2.

Source files
------------

// File: rtl/uop_pkg.sv
// Shared types and constants for the micro-op issue queue.
package uop_pkg;

   localparam int UOP_W         = 20;
   localparam int K_W           = 16;
   localparam int DEFAULT_DEPTH = 8;
   localparam int MAX_BUNDLE    = 3;

   typedef struct packed {
      logic [UOP_W-1:0] uop;
      logic [K_W-1:0]   k;
   } uop_entry_t;

endpackage

// File: rtl/uop_queue_if.sv
// Front-end feed and execute issue signals of the micro-op queue.
// Handshakes: a bundle transfers on a cycle where fe_feed_req & fe_feed_ack; a uop
// issues on a cycle where ex_valid & ex_ready. fe_feed_req never depends on fe_feed_ack.
interface uop_queue_if
   import uop_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
);
   localparam int OCC_W = $clog2(DEPTH) + 1;

   logic             fe_feed_req;
   logic             fe_feed_ack;
   logic [UOP_W-1:0] fe_uop_0;
   logic [UOP_W-1:0] fe_uop_1;
   logic [UOP_W-1:0] fe_uop_2;
   logic [1:0]       fe_uop_count;
   logic [K_W-1:0]   fe_k;
   logic             ex_flush;
   logic             ex_valid;
   logic             ex_ready;
   logic [UOP_W-1:0] ex_uop;
   logic [K_W-1:0]   ex_k;
   logic [OCC_W-1:0] occupancy;

   // Queue side.
   modport slave (
      output fe_feed_req, ex_valid, ex_uop, ex_k, occupancy,
      input  fe_feed_ack, fe_uop_0, fe_uop_1, fe_uop_2, fe_uop_count, fe_k,
      input  ex_flush, ex_ready
   );

   // Front end / execute side.
   modport master (
      input  fe_feed_req, ex_valid, ex_uop, ex_k, occupancy,
      output fe_feed_ack, fe_uop_0, fe_uop_1, fe_uop_2, fe_uop_count, fe_k,
      output ex_flush, ex_ready
   );

endinterface

// File: rtl/uop_ring.sv
// Ring storage for the micro-op queue: three write ports at consecutive addresses
// (wrapping modulo DEPTH) with per-port enables and one asynchronous read port.
module uop_ring
   import uop_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                              clk,
   input  logic [MAX_BUNDLE-1:0]             wr_en,
   input  logic [$clog2(DEPTH)-1:0]          wr_addr,
   input  uop_entry_t [MAX_BUNDLE-1:0]       wr_data,
   input  logic [$clog2(DEPTH)-1:0]          rd_addr,
   output uop_entry_t                        rd_data
);
   localparam int PTR_W = $clog2(DEPTH);

   // Storage is deliberately left unreset; occupancy gates every read.
   uop_entry_t mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int i = 0; i < MAX_BUNDLE; i++) begin
         if (wr_en[i]) begin
            mem[wr_addr + PTR_W'(i)] <= wr_data[i];
         end
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uop_queue.sv
// Micro-op issue queue: buffers decoded bundles and issues one uop per cycle.
// Optional same-cycle bypass of an empty queue is enabled by UOP_QUEUE_BYPASS_EN.
module uop_queue
   import uop_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input logic        clk,
   input logic        a_rst,
   uop_queue_if.slave q
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   logic [PTR_W-1:0]            rd_ptr, wr_ptr;
   logic [OCC_W-1:0]            occ, occ_next, free_cnt, n_store;
   logic                        push, pop_mem, mem_valid, byp, byp_take;
   logic [MAX_BUNDLE-1:0]       wr_en;
   uop_entry_t [MAX_BUNDLE-1:0] wr_data;
   uop_entry_t                  head;

   assign free_cnt       = OCC_W'(DEPTH) - occ;
   assign q.fe_feed_req  = (free_cnt >= OCC_W'(MAX_BUNDLE)) && !q.ex_flush;
   assign push           = q.fe_feed_req && q.fe_feed_ack;
   assign mem_valid      = (occ != '0);
   assign pop_mem        = mem_valid && q.ex_ready;

`ifdef UOP_QUEUE_BYPASS_EN
   // push is already blocked during flush, so the bypass is too.
   assign byp = push && !mem_valid && (q.fe_uop_count != 2'd0);
`else
   assign byp = 1'b0;
`endif
   assign byp_take = byp && q.ex_ready;

   assign q.ex_valid  = mem_valid || byp;
   assign q.occupancy = occ;

   always_comb begin
      q.ex_uop = '0;
      q.ex_k   = '0;
      if (mem_valid) begin
         q.ex_uop = head.uop;
         q.ex_k   = head.k;
      end else if (byp) begin
         q.ex_uop = q.fe_uop_0;
         q.ex_k   = q.fe_k;
      end
   end

   // When uop_0 leaves through the bypass, the remaining uops slide down one port.
   always_comb begin
      wr_data[0] = '{uop: q.fe_uop_0, k: q.fe_k};
      wr_data[1] = '{uop: q.fe_uop_1, k: q.fe_k};
      wr_data[2] = '{uop: q.fe_uop_2, k: q.fe_k};
      n_store    = '0;
      if (push) begin
         n_store = OCC_W'(q.fe_uop_count) - OCC_W'(byp_take);
      end
      if (byp_take) begin
         wr_data[0] = '{uop: q.fe_uop_1, k: q.fe_k};
         wr_data[1] = '{uop: q.fe_uop_2, k: q.fe_k};
      end
      for (int i = 0; i < MAX_BUNDLE; i++) begin
         wr_en[i] = (OCC_W'(i) < n_store);
      end
   end

   assign occ_next = occ + n_store - OCC_W'(pop_mem);

   always_ff @(posedge clk or negedge a_rst) begin
      if (!a_rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
      end else if (q.ex_flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
      end else begin
         rd_ptr <= rd_ptr + PTR_W'(pop_mem);
         wr_ptr <= wr_ptr + n_store[PTR_W-1:0];
         occ    <= occ_next;
      end
   end

   uop_ring #(.DEPTH(DEPTH)) u_ring (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (wr_data),
      .rd_addr (rd_ptr),
      .rd_data (head)
   );

endmodule

// File: tb/tb_uop_queue.sv
// Directed bench for uop_queue: driver tasks push bundles and queue expected
// issues; a negedge monitor pops and compares every issued uop.
module tb_uop_queue;
   import uop_pkg::*;

   localparam int DEPTH = 8;
   localparam int EW    = UOP_W + K_W;

   logic clk;
   logic a_rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [EW-1:0] exp_q[$];

   uop_queue_if #(.DEPTH(DEPTH)) qif ();

   uop_queue #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .a_rst (a_rst),
      .q     (qif)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: a handshake during flush is discarded by the queue.
   always @(negedge clk) begin
      if (a_rst && !qif.ex_flush && qif.ex_valid && qif.ex_ready) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL issue_unexpected: got uop 0x%0h k 0x%0h, expected no issue at %0t",
                     qif.ex_uop, qif.ex_k, $time);
         end else begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            if ({qif.ex_uop, qif.ex_k} !== e) begin
               n_fail++;
               $display("FAIL issue_order: got uop 0x%0h k 0x%0h, expected uop 0x%0h k 0x%0h at %0t",
                        qif.ex_uop, qif.ex_k, e[EW-1:K_W], e[K_W-1:0], $time);
            end
         end
      end
   end

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic push(input logic [UOP_W-1:0] u0, input logic [UOP_W-1:0] u1,
                       input logic [UOP_W-1:0] u2, input logic [1:0] n,
                       input logic [K_W-1:0] k, input logic accept);
      logic [UOP_W-1:0] u [3];
      u[0] = u0; u[1] = u1; u[2] = u2;
      qif.fe_feed_ack  = 1'b1;
      qif.fe_uop_0     = u0;
      qif.fe_uop_1     = u1;
      qif.fe_uop_2     = u2;
      qif.fe_uop_count = n;
      qif.fe_k         = k;
      #1;
      chk("push_feed_req", 64'(qif.fe_feed_req), 64'(accept));
      if (accept) begin
         for (int i = 0; i < int'(n); i++) exp_q.push_back({u[i], k});
      end
      tick();
      qif.fe_feed_ack  = 1'b0;
      qif.fe_uop_count = 2'd0;
   endtask

   initial begin
      a_rst            = 1'b0;
      qif.fe_feed_ack  = 1'b0;
      qif.fe_uop_0     = '0;
      qif.fe_uop_1     = '0;
      qif.fe_uop_2     = '0;
      qif.fe_uop_count = 2'd0;
      qif.fe_k         = '0;
      qif.ex_flush     = 1'b0;
      qif.ex_ready     = 1'b0;

      // Reset
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ex_valid", 64'(qif.ex_valid), 64'd0);
      chk("rst_ex_uop", 64'(qif.ex_uop), 64'd0);
      chk("rst_ex_k", 64'(qif.ex_k), 64'd0);
      chk("rst_occupancy", 64'(qif.occupancy), 64'd0);
      a_rst = 1'b1;
      tick();
      chk("rst_feed_req", 64'(qif.fe_feed_req), 64'd1);
      chk("rst_ex_valid_post", 64'(qif.ex_valid), 64'd0);

      // Bundle order
      qif.ex_ready = 1'b1;
      push(20'h00001, 20'h00002, 20'h00003, 2'd3, 16'h1234, 1'b1);
      run_cycles(4);
      chk("order_drained_occ", 64'(qif.occupancy), 64'd0);

      // Full
      qif.ex_ready = 1'b0;
      push(20'h00101, 20'h00102, 20'h00103, 2'd3, 16'h0F0F, 1'b1);
      push(20'h00104, 20'h00105, 20'h00106, 2'd3, 16'h0F0F, 1'b1);
      #1;
      chk("full_occ6", 64'(qif.occupancy), 64'd6);
      chk("full_feed_req0", 64'(qif.fe_feed_req), 64'd0);
      push(20'h001FF, 20'h001FE, 20'h001FD, 2'd3, 16'hDEAD, 1'b0);
      #1;
      chk("full_ignored_occ", 64'(qif.occupancy), 64'd6);
      qif.ex_ready = 1'b1;
      tick();
      qif.ex_ready = 1'b0;
      #1;
      chk("full_pop_occ5", 64'(qif.occupancy), 64'd5);
      chk("full_pop_feed_req1", 64'(qif.fe_feed_req), 64'd1);
      qif.ex_ready = 1'b1;
      run_cycles(6);
      chk("full_drained_occ", 64'(qif.occupancy), 64'd0);

      // Wrap: pointers at 1, advance to 6 then push across the end of the ring
      qif.ex_ready = 1'b0;
      push(20'h00201, 20'h00202, 20'h00203, 2'd3, 16'h2020, 1'b1);
      push(20'h00204, 20'h00205, 20'h00000, 2'd2, 16'h2021, 1'b1);
      qif.ex_ready = 1'b1;
      run_cycles(6);
      chk("wrap_pre_occ", 64'(qif.occupancy), 64'd0);
      qif.ex_ready = 1'b0;
      push(20'h0000A, 20'h0000B, 20'h0000C, 2'd3, 16'h5A5A, 1'b1);
      #1;
      chk("wrap_occ3", 64'(qif.occupancy), 64'd3);
      push(20'h00000, 20'h00000, 20'h00000, 2'd0, 16'h7777, 1'b1);
      #1;
      chk("n0_occ_unchanged", 64'(qif.occupancy), 64'd3);
      qif.ex_ready = 1'b1;
      run_cycles(4);
      chk("wrap_drained_occ", 64'(qif.occupancy), 64'd0);

      // Flush with same-cycle push and pop
      qif.ex_ready = 1'b0;
      push(20'h00301, 20'h00302, 20'h00303, 2'd3, 16'h1111, 1'b1);
      push(20'h00304, 20'h00000, 20'h00000, 2'd1, 16'h2222, 1'b1);
      qif.fe_feed_ack  = 1'b1;
      qif.fe_uop_0     = 20'h003A0;
      qif.fe_uop_1     = 20'h003A1;
      qif.fe_uop_count = 2'd2;
      qif.fe_k         = 16'h3333;
      qif.ex_ready     = 1'b1;
      qif.ex_flush     = 1'b1;
      #1;
      chk("flush_feed_req0", 64'(qif.fe_feed_req), 64'd0);
      chk("flush_occ4", 64'(qif.occupancy), 64'd4);
      tick();
      qif.ex_flush     = 1'b0;
      qif.fe_feed_ack  = 1'b0;
      qif.fe_uop_count = 2'd0;
      qif.ex_ready     = 1'b0;
      exp_q.delete();
      #1;
      chk("flush_occ0", 64'(qif.occupancy), 64'd0);
      chk("flush_ex_valid0", 64'(qif.ex_valid), 64'd0);
      chk("flush_ex_uop0", 64'(qif.ex_uop), 64'd0);
      qif.ex_ready = 1'b1;
      run_cycles(4);
      chk("flush_stays_empty", 64'(qif.occupancy), 64'd0);

      // Bypass / minimum latency from an empty queue
      qif.fe_feed_ack  = 1'b1;
      qif.fe_uop_0     = 20'h00011;
      qif.fe_uop_1     = 20'h00022;
      qif.fe_uop_count = 2'd2;
      qif.fe_k         = 16'hBEEF;
      exp_q.push_back({20'h00011, 16'hBEEF});
      exp_q.push_back({20'h00022, 16'hBEEF});
      #1;
`ifdef UOP_QUEUE_BYPASS_EN
      chk("byp_c0_valid", 64'(qif.ex_valid), 64'd1);
      chk("byp_c0_uop", 64'(qif.ex_uop), 64'h00011);
      chk("byp_c0_k", 64'(qif.ex_k), 64'hBEEF);
`else
      chk("byp_c0_valid", 64'(qif.ex_valid), 64'd0);
      chk("byp_c0_uop", 64'(qif.ex_uop), 64'd0);
`endif
      tick();
      qif.fe_feed_ack  = 1'b0;
      qif.fe_uop_count = 2'd0;
      #1;
`ifdef UOP_QUEUE_BYPASS_EN
      chk("byp_c1_uop", 64'(qif.ex_uop), 64'h00022);
      chk("byp_c1_occ", 64'(qif.occupancy), 64'd1);
`else
      chk("byp_c1_uop", 64'(qif.ex_uop), 64'h00011);
      chk("byp_c1_occ", 64'(qif.occupancy), 64'd2);
`endif
      tick();
      #1;
`ifdef UOP_QUEUE_BYPASS_EN
      chk("byp_c2_valid", 64'(qif.ex_valid), 64'd0);
`else
      chk("byp_c2_uop", 64'(qif.ex_uop), 64'h00022);
`endif
      tick();
      #1;
      chk("byp_end_valid", 64'(qif.ex_valid), 64'd0);
      chk("byp_end_occ", 64'(qif.occupancy), 64'd0);

      // Final report
      tick();
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
